// File: rtl/lab4_alu_sequencer.sv
// rtl/lab4_alu_sequencer.sv - 8x32 register file and command sequencer in front of lab4_alu
// Optional statistics counters are enabled by defining ALU_SEQ_STATS_EN.
module lab4_alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_func,
  input  logic [2:0]  cmd_rd,
  input  logic [2:0]  cmd_ra,
  input  logic [2:0]  cmd_rb,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [2:0]  ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [4:0]  alu_func,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_ovf,
  output logic        rsp_err
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_ovf
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [4:0] FUNC_AND = 5'b11000;

  state_t      state, state_nx;
  logic [31:0] rf [8];
  logic [31:0] a_q, b_q;
  logic [4:0]  func_q;
  logic [2:0]  rd_q;
  logic        cmd_accept;
  logic        ld_accept;
  logic        func_illegal;
  logic        func_addsub;

  assign cmd_ready  = (state == IDLE) && rst_n;
  assign ld_ready   = (state == IDLE) && rst_n;
  assign cmd_accept = cmd_valid && cmd_ready;
  assign ld_accept  = ld_valid && ld_ready;
  assign rsp_valid  = (state == RESP);

  assign func_illegal = (func_q[4:1] == 4'b1010) || (func_q[4:2] == 3'b111);
  assign func_addsub  = (func_q[4:1] == 4'b1011);

  // The ALU sees a fixed AND outside EXEC so its inputs are never left undefined.
  assign alu_A    = a_q;
  assign alu_B    = b_q;
  assign alu_func = (state == EXEC) ? func_q : FUNC_AND;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_valid) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      func_q   <= '0;
      rd_q     <= '0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_ovf  <= 1'b0;
      rsp_err  <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      state <= state_nx;
      // Operands sample the pre-edge file, so a same-cycle load is not seen.
      if (cmd_accept) begin
        a_q    <= rf[cmd_ra];
        b_q    <= rf[cmd_rb];
        func_q <= cmd_func;
        rd_q   <= cmd_rd;
      end
      if (ld_accept && (ld_addr != 3'd0)) rf[ld_addr] <= ld_data;
      if (state == EXEC) begin
        rsp_err  <= func_illegal;
        rsp_data <= func_illegal ? 32'd0 : alu_result;
        rsp_zero <= func_illegal ? 1'b0 : alu_zero;
        rsp_ovf  <= func_addsub ? alu_overflow : 1'b0;
        if (!func_illegal && (rd_q != 3'd0)) rf[rd_q] <= alu_result;
      end
    end
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops <= '0;
      stat_ovf <= '0;
    end else if (rsp_valid && rsp_ready && !rsp_err) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (rsp_ovf && (stat_ovf != 16'hFFFF)) stat_ovf <= stat_ovf + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lab4_alu_sequencer.sv
// tb/tb_lab4_alu_sequencer.sv - directed self-checking bench for lab4_alu_sequencer
module tb_lab4_alu_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [4:0]  cmd_func;
  logic [2:0]  cmd_rd, cmd_ra, cmd_rb;
  logic        ld_valid, ld_ready;
  logic [2:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] alu_A, alu_B, alu_result;
  logic [4:0]  alu_func;
  logic        alu_zero, alu_overflow;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero, rsp_ovf, rsp_err;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops, stat_ovf;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lab4_alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
    .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_A(alu_A), .alu_B(alu_B), .alu_func(alu_func),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
`ifdef ALU_SEQ_STATS_EN
    , .stat_ops(stat_ops), .stat_ovf(stat_ovf)
`endif
  );

  // ALU stand-in; overflow is deliberately 1 outside add/sub since it is don't-care there.
  always_comb begin
    alu_result   = alu_A & alu_B;
    alu_overflow = 1'b1;
    case (alu_func)
      5'b10110: begin
        alu_result   = alu_A + alu_B;
        alu_overflow = (alu_A[31] == alu_B[31]) && (alu_result[31] != alu_A[31]);
      end
      5'b10111: begin
        alu_result   = alu_A - alu_B;
        alu_overflow = (alu_A[31] != alu_B[31]) && (alu_result[31] != alu_A[31]);
      end
      5'b11011: alu_result = alu_A ^ alu_B;
      default:  alu_result = alu_A & alu_B;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // All stimulus tasks start and end at a falling edge.
  task automatic load(input logic [2:0] a, input logic [31:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic [4:0] f, input logic [2:0] rd,
                         input logic [2:0] ra, input logic [2:0] rb, input logic [31:0] e_data,
                         input logic e_zero, input logic e_ovf, input logic e_err);
    check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_func = f; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
    @(negedge clk);
    cmd_valid = 1'b0; ld_valid = 1'b0;
    check({tag, ".exec_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".exec_func"}, 32'(alu_func), 32'(f));
    @(negedge clk);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".data"}, rsp_data, e_data);
    check({tag, ".zero"}, 32'(rsp_zero), 32'(e_zero));
    check({tag, ".ovf"}, 32'(rsp_ovf), 32'(e_ovf));
    check({tag, ".err"}, 32'(rsp_err), 32'(e_err));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_func = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; rsp_ready = 1'b1;
    #12;
    check("rst.cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst.ld_ready", 32'(ld_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.cmd_ready_rel", 32'(cmd_ready), 32'd1);
    check("rst.ld_ready_rel", 32'(ld_ready), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.alu_func", 32'(alu_func), 32'h18);
    check("rst.alu_A", alu_A, 32'd0);
    check("rst.alu_B", alu_B, 32'd0);
    check("rst.rsp_data", rsp_data, 32'd0);
    check("rst.flags", {29'd0, rsp_zero, rsp_ovf, rsp_err}, 32'd0);

    load(3'd1, 32'd5);
    load(3'd2, 32'd7);
    run_cmd("add", 5'b10110, 3'd3, 3'd1, 3'd2, 32'd12, 1'b0, 1'b0, 1'b0);
    run_cmd("rd_r3", 5'b10110, 3'd0, 3'd3, 3'd0, 32'd12, 1'b0, 1'b0, 1'b0);

    load(3'd1, 32'h7FFF_FFFF);
    load(3'd2, 32'd1);
    run_cmd("add_ovf", 5'b10110, 3'd4, 3'd1, 3'd2, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

    load(3'd1, 32'hA5A5_A5A5);
    load(3'd2, 32'hA5A5_A5A5);
    run_cmd("xor", 5'b11011, 3'd5, 3'd1, 3'd2, 32'd0, 1'b1, 1'b0, 1'b0);
    run_cmd("sub_same", 5'b10111, 3'd5, 3'd5, 3'd5, 32'd0, 1'b1, 1'b0, 1'b0);

    load(3'd6, 32'h0000_1234);
    run_cmd("illegal", 5'b11100, 3'd6, 3'd1, 3'd2, 32'd0, 1'b0, 1'b0, 1'b1);
    run_cmd("rd_r6", 5'b10110, 3'd0, 3'd6, 3'd0, 32'h0000_1234, 1'b0, 1'b0, 1'b0);

    load(3'd0, 32'hFFFF_FFFF);
    run_cmd("rd_r0", 5'b10110, 3'd0, 3'd0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Same-edge load and command: the command sees the old r1.
    ld_valid = 1'b1; ld_addr = 3'd1; ld_data = 32'h10;
    run_cmd("rbw", 5'b10110, 3'd7, 3'd1, 3'd0, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0);
    run_cmd("rd_r1", 5'b10110, 3'd0, 3'd1, 3'd0, 32'h10, 1'b0, 1'b0, 1'b0);

    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_func = 5'b10110; cmd_rd = 3'd0; cmd_ra = 3'd3; cmd_rb = 3'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_func = 5'b11011; cmd_rd = 3'd0; cmd_ra = 3'd3; cmd_rb = 3'd3;
    for (int i = 0; i < 10; i++) begin
      check("bp.rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp.rsp_data", rsp_data, 32'd12);
      check("bp.cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp.release_ready", 32'(cmd_ready), 32'd1);
    check("bp.release_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp.accepted", 32'(cmd_ready), 32'd0);
    check("bp.exec_func", 32'(alu_func), 32'h1B);
    @(negedge clk);
    check("bp.next_data", rsp_data, 32'd0);
    check("bp.next_zero", 32'(rsp_zero), 32'd1);
    @(negedge clk);

`ifdef ALU_SEQ_STATS_EN
    check("stat.ops", 32'(stat_ops), 32'd11);
    check("stat.ovf", 32'(stat_ovf), 32'd1);
`endif

    cmd_valid = 1'b1; cmd_func = 5'b10110; cmd_rd = 3'd3; cmd_ra = 3'd1; cmd_rb = 3'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid.in_exec", 32'(alu_func), 32'h16);
    rst_n = 1'b0;
    #1;
    check("mid.cmd_ready", 32'(cmd_ready), 32'd0);
    check("mid.rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid.alu_func", 32'(alu_func), 32'h18);
    check("mid.alu_A", alu_A, 32'd0);
    check("mid.rsp_data", rsp_data, 32'd0);
`ifdef ALU_SEQ_STATS_EN
    check("mid.stat_ops", 32'(stat_ops), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid.no_rsp", 32'(rsp_valid), 32'd0);
      check("mid.idle", 32'(cmd_ready), 32'd1);
    end
    run_cmd("post_rst_r3", 5'b10110, 3'd0, 3'd3, 3'd0, 32'd0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
